// File: rtl/temporary_id_allocator_pkg.sv
// Shared types and constants for the temporary node-ID allocator.
package temporary_id_allocator_pkg;

  // Default node ID width used by the router codebase.
  localparam int unsigned ID_WIDTH_DEF = 8;

  // Node identifier as carried in packet headers.
  typedef logic [ID_WIDTH_DEF-1:0] node_id_t;

  // Reserved identifiers that can never be owned by a node.
  localparam node_id_t ID_INVALID   = 8'h00;
  localparam node_id_t ID_BROADCAST = 8'hFF;

  // Allocation sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQUEST = 3'd1,
    ST_CLAIM   = 3'd2,
    ST_LISTEN  = 3'd3,
    ST_DONE    = 3'd4,
    ST_FAIL    = 3'd5
  } alloc_state_t;

endpackage

// File: rtl/temporary_id_allocator_listen_timer.sv
// Loadable down-counter timing the post-claim listen window.
// 'expired' flags the final window cycle: the decrement taken on this
// edge brings the count to zero.
module listen_timer
  import temporary_id_allocator_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 64,
  localparam int unsigned TW = $clog2(WAIT_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          dec,
  input  logic [TW-1:0] load_value,
  output logic          expired
);

  localparam logic [TW-1:0] ONE_L  = TW'(32'd1);
  localparam logic [TW-1:0] ZERO_L = TW'(32'd0);

  logic [TW-1:0] count_r;

  // Count register: load wins over decrement, holds at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= ZERO_L;
    end else if (load) begin
      count_r <= load_value;
    end else if (dec && (count_r != ZERO_L)) begin
      count_r <= count_r - ONE_L;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == ONE_L);

endmodule

// File: rtl/temporary_id_allocator.sv
// Temporary node-ID allocator: draws a random ID, claims it, listens for
// conflicting traffic over a fixed window and retries on collision.
module temporary_id_allocator
  import temporary_id_allocator_pkg::*;
#(
  parameter int unsigned ID_WIDTH    = 8,
  parameter int unsigned WAIT_CYCLES = 64,
  parameter int unsigned MAX_RETRY   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                rnd_req,
  input  logic                rnd_valid,
  input  logic [ID_WIDTH-1:0] rnd_id,
  output logic                claim_valid,
  output logic [ID_WIDTH-1:0] claim_id,
  input  logic                claim_ready,
  input  logic                rx_valid,
  input  logic [ID_WIDTH-1:0] rx_src_id,
  input  logic                rx_is_claim,
  output logic                id_valid,
  output logic [ID_WIDTH-1:0] node_id,
  output logic                fail,
  output logic                busy
);

  localparam int unsigned TW = $clog2(WAIT_CYCLES + 1);
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  localparam logic [ID_WIDTH-1:0] ID_ZERO_L  = {ID_WIDTH{1'b0}};
  localparam logic [ID_WIDTH-1:0] ID_BCAST_L = {ID_WIDTH{1'b1}};
  localparam logic [TW-1:0]       WAIT_L     = TW'(WAIT_CYCLES);
  localparam logic [RW-1:0]       RETRY_MAX_L  = RW'(MAX_RETRY);
  localparam logic [RW-1:0]       RETRY_ONE_L  = RW'(32'd1);
  localparam logic [RW-1:0]       RETRY_ZERO_L = RW'(32'd0);

  alloc_state_t        state_r, state_n;
  logic [ID_WIDTH-1:0] cand_r, cand_n;
  logic [RW-1:0]       retry_r, retry_n;
  logic                pending_r, pending_n;

  logic                timer_load_s, timer_dec_s, timer_expired_s;
  logic                reserved_s, conflict_s, foreign_claim_s;

  logic                rnd_req_n, claim_valid_n, id_valid_n, fail_n, busy_n;
  logic [ID_WIDTH-1:0] claim_id_n, node_id_n;

  listen_timer #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_listen_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load_s),
    .dec        (timer_dec_s),
    .load_value (WAIT_L),
    .expired    (timer_expired_s)
  );

  assign reserved_s      = (rnd_id == ID_ZERO_L) || (rnd_id == ID_BCAST_L);
  assign conflict_s      = rx_valid && (rx_src_id == cand_r);
  assign foreign_claim_s = rx_valid && rx_is_claim && (rx_src_id == cand_r);

  // Next-state and datapath update for the allocation sequencer.
  always_comb begin
    state_n      = state_r;
    cand_n       = cand_r;
    retry_n      = retry_r;
    pending_n    = pending_r;
    timer_load_s = 1'b0;
    timer_dec_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_FAIL: begin
        if (start) begin
          state_n   = ST_REQUEST;
          retry_n   = RETRY_ZERO_L;
          pending_n = 1'b0;
        end else begin
          state_n = state_r;
        end
      end
      ST_REQUEST: begin
        // Reserved values are dropped without touching the retry count.
        if (rnd_valid && !reserved_s) begin
          state_n   = ST_CLAIM;
          cand_n    = rnd_id;
          pending_n = 1'b0;
        end else begin
          state_n = ST_REQUEST;
        end
      end
      ST_CLAIM: begin
        // A conflict during the claim is remembered and acted on in LISTEN.
        pending_n = pending_r || conflict_s;
        if (claim_ready) begin
          state_n      = ST_LISTEN;
          timer_load_s = 1'b1;
        end else begin
          state_n = ST_CLAIM;
        end
      end
      ST_LISTEN: begin
        timer_dec_s = 1'b1;
        // Conflict beats window expiry on the final cycle.
        if (conflict_s || pending_r) begin
          retry_n   = retry_r + RETRY_ONE_L;
          pending_n = 1'b0;
          if (retry_n == RETRY_MAX_L) begin
            state_n = ST_FAIL;
          end else begin
            state_n = ST_REQUEST;
          end
        end else if (timer_expired_s) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_LISTEN;
        end
      end
      ST_DONE: begin
        // Only a foreign claim on our ID forces reallocation.
        if (start || foreign_claim_s) begin
          state_n   = ST_REQUEST;
          retry_n   = RETRY_ZERO_L;
          pending_n = 1'b0;
        end else begin
          state_n = ST_DONE;
        end
      end
      default: begin
        state_n   = ST_IDLE;
        retry_n   = RETRY_ZERO_L;
        pending_n = 1'b0;
      end
    endcase
  end

  // Output values decoded from the next state so outputs can be registered.
  always_comb begin
    rnd_req_n     = (state_n == ST_REQUEST);
    claim_valid_n = (state_n == ST_CLAIM);
    id_valid_n    = (state_n == ST_DONE);
    fail_n        = (state_n == ST_FAIL);
    busy_n        = (state_n == ST_REQUEST) || (state_n == ST_CLAIM) ||
                    (state_n == ST_LISTEN);
    if (claim_valid_n) begin
      claim_id_n = cand_n;
    end else begin
      claim_id_n = ID_ZERO_L;
    end
    if (id_valid_n) begin
      node_id_n = cand_n;
    end else begin
      node_id_n = ID_ZERO_L;
    end
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cand_r      <= ID_ZERO_L;
      retry_r     <= RETRY_ZERO_L;
      pending_r   <= 1'b0;
      rnd_req     <= 1'b0;
      claim_valid <= 1'b0;
      claim_id    <= ID_ZERO_L;
      id_valid    <= 1'b0;
      node_id     <= ID_ZERO_L;
      fail        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_r     <= state_n;
      cand_r      <= cand_n;
      retry_r     <= retry_n;
      pending_r   <= pending_n;
      rnd_req     <= rnd_req_n;
      claim_valid <= claim_valid_n;
      claim_id    <= claim_id_n;
      id_valid    <= id_valid_n;
      node_id     <= node_id_n;
      fail        <= fail_n;
      busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_temporary_id_allocator.sv
// Self-checking bench for temporary_id_allocator (WAIT_CYCLES=8, MAX_RETRY=2).
module tb_temporary_id_allocator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       rnd_req;
  logic       rnd_valid;
  logic [7:0] rnd_id;
  logic       claim_valid;
  logic [7:0] claim_id;
  logic       claim_ready;
  logic       rx_valid;
  logic [7:0] rx_src_id;
  logic       rx_is_claim;
  logic       id_valid;
  logic [7:0] node_id;
  logic       fail;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_claim_q[$];
  logic [7:0] exp_node_q[$];
  logic       prev_cv = 1'b0;
  logic       prev_iv = 1'b0;

  temporary_id_allocator #(
    .ID_WIDTH    (8),
    .WAIT_CYCLES (8),
    .MAX_RETRY   (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .rnd_req     (rnd_req),
    .rnd_valid   (rnd_valid),
    .rnd_id      (rnd_id),
    .claim_valid (claim_valid),
    .claim_id    (claim_id),
    .claim_ready (claim_ready),
    .rx_valid    (rx_valid),
    .rx_src_id   (rx_src_id),
    .rx_is_claim (rx_is_claim),
    .id_valid    (id_valid),
    .node_id     (node_id),
    .fail        (fail),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard: compare claim_id / node_id on each rising valid.
  always @(negedge clk) begin
    if (rst_n) begin
      if (claim_valid && !prev_cv) begin
        if (exp_claim_q.size() == 0) check_val("sb_claim_unexpected", 32'd1, 32'd0);
        else check_val("sb_claim_id", 32'(claim_id), 32'(exp_claim_q.pop_front()));
      end
      if (id_valid && !prev_iv) begin
        if (exp_node_q.size() == 0) check_val("sb_node_unexpected", 32'd1, 32'd0);
        else check_val("sb_node_id", 32'(node_id), 32'(exp_node_q.pop_front()));
      end
    end
    prev_cv <= claim_valid;
    prev_iv <= id_valid;
  end

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("start_rnd_req", 32'(rnd_req), 32'd1);
    check_val("start_busy", 32'(busy), 32'd1);
    check_val("start_id_valid", 32'(id_valid), 32'd0);
    check_val("start_fail", 32'(fail), 32'd0);
  endtask

  task automatic give_rnd(input logic [7:0] v, input logic accept);
    check_val("req_before_rnd", 32'(rnd_req), 32'd1);
    rnd_valid = 1'b1;
    rnd_id    = v;
    if (accept) exp_claim_q.push_back(v);
    tick();
    rnd_valid = 1'b0;
    rnd_id    = 8'h00;
    if (accept) begin
      check_val("claim_valid_rise", 32'(claim_valid), 32'd1);
      check_val("rnd_req_drop", 32'(rnd_req), 32'd0);
    end else begin
      check_val("discard_rnd_req", 32'(rnd_req), 32'd1);
      check_val("discard_no_claim", 32'(claim_valid), 32'd0);
    end
  endtask

  // Handshake edge, then a full clean window; id_valid rises after WAIT edges.
  task automatic listen_clean(input logic [7:0] v);
    tick();
    check_val("listen_no_claim", 32'(claim_valid), 32'd0);
    check_val("listen_early", 32'(id_valid), 32'd0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check_val("listen_early", 32'(id_valid), 32'd0);
    end
    tick();
    check_val("done_id_valid", 32'(id_valid), 32'd1);
    check_val("done_node_id", 32'(node_id), 32'(v));
    check_val("done_busy", 32'(busy), 32'd0);
  endtask

  // Handshake edge, then a conflict on LISTEN cycle c (1-based).
  task automatic listen_conflict(input int c, input logic [7:0] src);
    tick();
    for (int i = 1; i < c; i++) tick();
    rx_valid    = 1'b1;
    rx_src_id   = src;
    rx_is_claim = 1'b0;
    tick();
    rx_valid  = 1'b0;
    rx_src_id = 8'h00;
  endtask

  task automatic rx_pulse(input logic [7:0] src, input logic is_claim);
    rx_valid    = 1'b1;
    rx_src_id   = src;
    rx_is_claim = is_claim;
    tick();
    rx_valid    = 1'b0;
    rx_src_id   = 8'h00;
    rx_is_claim = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rnd_valid = 1'b0; rnd_id = 8'h00;
    claim_ready = 1'b0; rx_valid = 1'b0; rx_src_id = 8'h00; rx_is_claim = 1'b0;
    tick(); tick();
    check_val("rst_rnd_req", 32'(rnd_req), 32'd0);
    check_val("rst_claim_valid", 32'(claim_valid), 32'd0);
    check_val("rst_claim_id", 32'(claim_id), 32'd0);
    check_val("rst_id_valid", 32'(id_valid), 32'd0);
    check_val("rst_node_id", 32'(node_id), 32'd0);
    check_val("rst_fail", 32'(fail), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    check_val("idle_busy", 32'(busy), 32'd0);

    // Clean allocation of 0x5A.
    claim_ready = 1'b1;
    pulse_start();
    exp_node_q.push_back(8'h5A);
    give_rnd(8'h5A, 1'b1);
    listen_clean(8'h5A);

    // Reserved values discarded, then a conflict on the final window cycle.
    pulse_start();
    give_rnd(8'h00, 1'b0);
    give_rnd(8'hFF, 1'b0);
    give_rnd(8'h33, 1'b1);
    listen_conflict(8, 8'h33);
    check_val("final_cyc_no_done", 32'(id_valid), 32'd0);
    check_val("final_cyc_retry_req", 32'(rnd_req), 32'd1);
    check_val("final_cyc_no_fail", 32'(fail), 32'd0);
    exp_node_q.push_back(8'h44);
    give_rnd(8'h44, 1'b1);
    listen_clean(8'h44);

    // Conflict retry: 0x10 collides in LISTEN cycle 3, 0x11 succeeds.
    pulse_start();
    give_rnd(8'h10, 1'b1);
    listen_conflict(3, 8'h10);
    check_val("retry_rnd_req", 32'(rnd_req), 32'd1);
    check_val("retry_no_fail", 32'(fail), 32'd0);
    exp_node_q.push_back(8'h11);
    give_rnd(8'h11, 1'b1);
    listen_clean(8'h11);

    // DONE: non-claim and other-ID claims ignored, foreign claim on ours evicts.
    rx_pulse(8'h11, 1'b0);
    check_val("done_ignore_nonclaim", 32'(id_valid), 32'd1);
    rx_pulse(8'h22, 1'b1);
    check_val("done_ignore_other", 32'(id_valid), 32'd1);
    rx_pulse(8'h11, 1'b1);
    check_val("foreign_id_valid", 32'(id_valid), 32'd0);
    check_val("foreign_rnd_req", 32'(rnd_req), 32'd1);

    // Exhaustion: conflict in LISTEN, then a conflict seen during a stalled CLAIM.
    give_rnd(8'h20, 1'b1);
    listen_conflict(1, 8'h20);
    check_val("exh1_rnd_req", 32'(rnd_req), 32'd1);
    check_val("exh1_no_fail", 32'(fail), 32'd0);
    claim_ready = 1'b0;
    give_rnd(8'h21, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_val("stall_claim_valid", 32'(claim_valid), 32'd1);
      check_val("stall_claim_id", 32'(claim_id), 32'h21);
      if (i == 1) rx_pulse(8'h21, 1'b1);
      else tick();
    end
    claim_ready = 1'b1;
    tick();
    check_val("pend_listen_busy", 32'(busy), 32'd1);
    check_val("pend_listen_nofail", 32'(fail), 32'd0);
    tick();
    check_val("exh_fail", 32'(fail), 32'd1);
    check_val("exh_id_valid", 32'(id_valid), 32'd0);
    check_val("exh_busy", 32'(busy), 32'd0);
    tick();
    check_val("fail_sticky", 32'(fail), 32'd1);
    pulse_start();

    // Async reset asserted mid-CLAIM.
    claim_ready = 1'b0;
    give_rnd(8'h66, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_claim_valid", 32'(claim_valid), 32'd0);
    check_val("arst_claim_id", 32'(claim_id), 32'd0);
    check_val("arst_rnd_req", 32'(rnd_req), 32'd0);
    check_val("arst_busy", 32'(busy), 32'd0);
    check_val("arst_id_valid", 32'(id_valid), 32'd0);
    check_val("arst_fail", 32'(fail), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_val("post_rst_idle", 32'(busy), 32'd0);
    check_val("post_rst_no_req", 32'(rnd_req), 32'd0);
    pulse_start();

    check_val("claim_q_left", 32'(exp_claim_q.size()), 32'd0);
    check_val("node_q_left", 32'(exp_node_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
